// File: rtl/fiveadder_operand_loader.sv
// fiveadder_operand_loader: synchronise and debounce operand buttons and commit, capture operands, strobe go/err.
module fiveadder_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PB1,
    input  logic       PB2,
    input  logic       PB3,
    input  logic       PB4,
    input  logic       ROT_SWITCH,
    input  logic [3:0] t,
    output logic [3:0] op1,
    output logic [3:0] op2,
    output logic [3:0] op3,
    output logic [3:0] op4,
    output logic [3:0] loaded,
    output logic       go,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, LOAD, FULL, ISSUE, HOLD} state_t;
    state_t state, state_nxt;
    logic [4:0] raw, s1, s2, deb, deb_d, rise;
    logic [3:0] t1, t2, rise_pb, loaded_nxt;
    logic [CNT_W-1:0] cnt [5];
    logic [3:0] ops [4];
    logic rise_rot, held;

    assign raw = {ROT_SWITCH, PB4, PB3, PB2, PB1};
    assign rise = deb & ~deb_d;
    assign rise_pb = rise[3:0];
    assign rise_rot = rise[4];
    assign held = state == ISSUE || state == HOLD;
    assign go = state == ISSUE;
    assign err = rise_rot && !(|rise_pb) && (state == IDLE || state == LOAD);
    assign {op4, op3, op2, op1} = {ops[3], ops[2], ops[1], ops[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1, s2, deb, deb_d} <= '0;
            {t1, t2, loaded} <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
            for (int k = 0; k < 4; k++) ops[k] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            t1 <= t;
            t2 <= t1;
            deb_d <= deb;
            loaded <= loaded_nxt;
            // a state flip needs DEBOUNCE_CYCLES consecutive disagreeing samples
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CNT_W'(1);
            end
            for (int k = 0; k < 4; k++) if (rise_pb[k]) ops[k] <= t2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // a press after an issue starts a fresh round; a press always wins over a same-cycle commit
    always_comb begin
        loaded_nxt = (held && |rise_pb) ? rise_pb : (loaded | rise_pb);
        state_nxt = |rise_pb ? ((loaded_nxt == 4'hF) ? FULL : LOAD)
                  : rise_rot ? ((state == FULL || held) ? ISSUE : state)
                  : (state == ISSUE) ? HOLD : state;
    end
endmodule

// File: tb/tb_fiveadder_operand_loader.sv
// tb_fiveadder_operand_loader: scoreboard bench with a rule-level operand/commit model.
module tb_fiveadder_operand_loader;
    localparam int DEB = 4;

    logic clk = 0, rst_n = 0;
    logic PB1 = 0, PB2 = 0, PB3 = 0, PB4 = 0, ROT_SWITCH = 0;
    logic [3:0] t = 0;
    logic [3:0] op1, op2, op3, op4, loaded;
    logic go, err;

    fiveadder_operand_loader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(18)) dut (
        .clk(clk), .rst_n(rst_n), .PB1(PB1), .PB2(PB2), .PB3(PB3), .PB4(PB4),
        .ROT_SWITCH(ROT_SWITCH), .t(t), .op1(op1), .op2(op2), .op3(op3), .op4(op4),
        .loaded(loaded), .go(go), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [15:0] ops;
        logic [3:0]  ld;
        int          t0;
    } ev_t;

    ev_t sb[$];
    int cyc = 0, checks = 0, passes = 0;
    bit armed = 0;
    logic [3:0] op_m [4];
    logic [3:0] ld_m;
    bit issued;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] pack_m();
        return {op_m[3], op_m[2], op_m[1], op_m[0]};
    endfunction

    // Monitor: every observable event (operand/loaded change, go, err) must match the queue head
    logic [15:0] prev_ops;
    logic [3:0] prev_ld, kind_a;
    ev_t e;
    int delta;
    always @(negedge clk) begin
        if (armed && (go || err || {op4, op3, op2, op1} != prev_ops || loaded != prev_ld)) begin
            kind_a = (go && err) ? 4'd3 : go ? 4'd1 : err ? 4'd2 : 4'd0;
            if (sb.size() == 0) chk(0, "unexpected_event", {8'h0, kind_a, op4, op3, op2, op1}, 32'h0);
            else begin
                e = sb.pop_front();
                chk({kind_a, op4, op3, op2, op1, loaded} == {e.kind, e.ops, e.ld}, "event",
                    {8'h0, kind_a, op4, op3, op2, op1, loaded}, {8'h0, e.kind, e.ops, e.ld});
                delta = cyc - e.t0;
                chk(delta >= DEB + 1 && delta <= DEB + 4, "latency", delta, DEB + 3);
            end
        end
        prev_ops = {op4, op3, op2, op1};
        prev_ld = loaded;
    end

    task automatic do_reset();
        armed = 0;
        @(posedge clk); #1;
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            {ROT_SWITCH, PB4, PB3, PB2, PB1} = 5'($urandom);
            t = 4'($urandom);
            @(negedge clk);
            chk({op4, op3, op2, op1, loaded, go, err} == 0, "reset_hold", {op4, op3, op2, op1, loaded, go, err}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        {ROT_SWITCH, PB4, PB3, PB2, PB1} = '0;
        t = 0;
        @(negedge clk);
        chk({op4, op3, op2, op1, loaded, go, err} == 0, "reset_after", {op4, op3, op2, op1, loaded, go, err}, 0);
        for (int k = 0; k < 4; k++) op_m[k] = 0;
        ld_m = 0;
        issued = 0;
        sb.delete();
        repeat (10) @(posedge clk);
        @(negedge clk);
        armed = 1;
    endtask

    // Drive a press pattern for 'hold' cycles; the model predicts the resulting event, if any
    task automatic act(input logic [3:0] m, input logic r, input logic [3:0] tv, input int hold);
        logic [15:0] old_ops;
        logic [3:0] old_ld;
        @(posedge clk); #1;
        t = tv;
        {PB4, PB3, PB2, PB1} = m;
        ROT_SWITCH = r;
        if (hold >= DEB) begin
            if (m != 0) begin
                old_ops = pack_m();
                old_ld = ld_m;
                ld_m = issued ? m : (ld_m | m);
                issued = 0;
                for (int k = 0; k < 4; k++) if (m[k]) op_m[k] = tv;
                if (pack_m() != old_ops || ld_m != old_ld) sb.push_back('{4'd0, pack_m(), ld_m, cyc});
            end else if (r) begin
                if (ld_m == 4'hF) begin
                    sb.push_back('{4'd1, pack_m(), ld_m, cyc});
                    issued = 1;
                end else sb.push_back('{4'd2, pack_m(), ld_m, cyc});
            end
        end
        repeat (hold) @(posedge clk);
        #1;
        {ROT_SWITCH, PB4, PB3, PB2, PB1} = '0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        chk(sb.size() == 0, "event_timeout", sb.size(), 0);
        sb.delete();
        repeat (DEB + 6) @(posedge clk);
    endtask

    initial begin
        do_reset();
        // debounce: short glitch ignored, long hold captures
        act(4'b0001, 0, 4'hF, 3);
        chk({op1, loaded} == 8'h00, "glitch", {op1, loaded}, 8'h00);
        act(4'b0001, 0, 4'hF, 10);
        chk({op1, loaded} == 8'hF1, "pb1_load", {op1, loaded}, 8'hF1);
        // full load and commit
        act(4'b0010, 0, 4'hD, 6);
        act(4'b0100, 0, 4'hE, 6);
        act(4'b1000, 0, 4'hB, 6);
        act(4'b0000, 1, 4'h0, 6);
        chk({op4, op3, op2, op1, loaded} == 20'hBEDFF, "issued_ops", {op4, op3, op2, op1, loaded}, 20'hBEDFF);
        act(4'b0000, 1, 4'h0, 6);
        // new round from HOLD
        act(4'b0100, 0, 4'h1, 6);
        chk({op4, op3, op2, op1, loaded} == 20'hB1DF4, "hold_press", {op4, op3, op2, op1, loaded}, 20'hB1DF4);
        act(4'b0000, 1, 4'h0, 6);
        act(4'b0001, 0, 4'h2, 6);
        act(4'b0010, 0, 4'h3, 6);
        act(4'b1000, 0, 4'h4, 6);
        act(4'b0000, 1, 4'h0, 6);
        // partial load commit gives err
        do_reset();
        act(4'b0001, 0, 4'h5, 6);
        act(4'b0010, 0, 4'h6, 6);
        act(4'b0000, 1, 4'h0, 6);
        chk(loaded == 4'b0011, "err_keeps_loaded", loaded, 4'b0011);
        act(4'b0100, 0, 4'h7, 6);
        act(4'b1000, 0, 4'h8, 6);
        // press and commit together in FULL: capture wins
        act(4'b0010, 1, 4'h9, 6);
        chk(op2 == 4'h9, "simul_recapture", op2, 4'h9);
        act(4'b0000, 1, 4'h0, 6);
        // reset mid-load discards progress
        act(4'b0001, 0, 4'hA, 6);
        do_reset();
        act(4'b0000, 1, 4'h0, 6);
        for (int n = 0; n < 40; n++) begin
            logic [3:0] m;
            logic r;
            m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            r = (m == 0) || ($urandom_range(0, 4) == 0);
            act(m, r, 4'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB - 1)) : int'($urandom_range(DEB, DEB + 4)));
        end
        chk({op4, op3, op2, op1, loaded} == {pack_m(), ld_m}, "final_state", {op4, op3, op2, op1, loaded}, {pack_m(), ld_m});
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
